// File: rtl/axis_burst_writer.sv
// Result-stream sink: buffers AXI-Stream words in a FIFO and drains them as AXI4 INCR write
// bursts into a circular address window. Define BURST_WRITER_FLUSH_EN to add the flush input.
module axis_burst_writer #(
    parameter int unsigned           DATA_WIDTH   = 16,
    parameter int unsigned           ADDR_WIDTH   = 32,
    parameter int unsigned           BURST_LEN    = 8,
    parameter int unsigned           FIFO_DEPTH   = 16,
    parameter logic [ADDR_WIDTH-1:0] BASE_ADDR    = '0,
    parameter int unsigned           WINDOW_BYTES = 1024
) (
    input  logic                      clk,
    input  logic                      rstn,
`ifdef BURST_WRITER_FLUSH_EN
    input  logic                      flush,
`endif
    input  logic                      s_axis_tvalid,
    output logic                      s_axis_tready,
    input  logic [DATA_WIDTH-1:0]     s_axis_tdata,
    output logic [ADDR_WIDTH-1:0]     m_axi_awaddr,
    output logic [7:0]                m_axi_awlen,
    output logic [2:0]                m_axi_awsize,
    output logic [1:0]                m_axi_awburst,
    output logic                      m_axi_awvalid,
    input  logic                      m_axi_awready,
    output logic [DATA_WIDTH-1:0]     m_axi_wdata,
    output logic [DATA_WIDTH/8-1:0]   m_axi_wstrb,
    output logic                      m_axi_wlast,
    output logic                      m_axi_wvalid,
    input  logic                      m_axi_wready,
    input  logic [1:0]                m_axi_bresp,
    input  logic                      m_axi_bvalid,
    output logic                      m_axi_bready,
    output logic [15:0]               bursts_done,
    output logic                      resp_err
);

    localparam int unsigned STRB_W = DATA_WIDTH / 8;
    localparam int unsigned AXSIZE = $clog2(STRB_W);
    localparam int unsigned PTR_W  = $clog2(FIFO_DEPTH);
    localparam int unsigned CNT_W  = PTR_W + 1;
    localparam int unsigned LEN_W  = 5;
    localparam int unsigned EXT_W  = ADDR_WIDTH + 1;
    localparam logic [EXT_W-1:0] WIN_END = EXT_W'(BASE_ADDR) + EXT_W'(WINDOW_BYTES);

    typedef enum logic [1:0] {S_IDLE, S_ADDR, S_DATA, S_RESP} state_e;

    state_e                  state_q, state_d;
    logic [DATA_WIDTH-1:0]   mem_q [FIFO_DEPTH];
    logic [PTR_W-1:0]        wr_ptr_q, rd_ptr_q;
    logic [CNT_W-1:0]        count_q, count_d;
    logic                    tready_q;
    logic                    push, pop;
    logic                    full_burst, flush_req, start;
    logic [LEN_W-1:0]        issue_len;
    logic [EXT_W-1:0]        issue_end, done_end;
    logic [ADDR_WIDTH-1:0]   cur_addr_q, cur_addr_d, awaddr_q, awaddr_d;
    logic [LEN_W-1:0]        len_q, len_d, beat_q, beat_d;
    logic                    awvalid_q, awvalid_d, wvalid_q, wvalid_d;
    logic                    wlast_q, wlast_d, bready_q, bready_d;
    logic [15:0]             bursts_q, bursts_d;
    logic                    resp_err_q, resp_err_d;

    assign push = s_axis_tvalid && tready_q;
    assign pop  = wvalid_q && m_axi_wready;

    always_comb begin
        count_d = count_q;
        case ({push, pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    // FIFO storage carries no reset; only pointers and count define its contents.
    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr_q] <= s_axis_tdata;
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            tready_q <= 1'b1;
        end else begin
            if (push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            if (pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            count_q  <= count_d;
            tready_q <= (count_d != CNT_W'(FIFO_DEPTH));
        end
    end

    assign full_burst = (count_q >= CNT_W'(BURST_LEN));
`ifdef BURST_WRITER_FLUSH_EN
    assign flush_req  = flush && (count_q != '0);
`else
    assign flush_req  = 1'b0;
`endif
    assign start     = full_burst || flush_req;
    assign issue_len = full_burst ? LEN_W'(BURST_LEN) : LEN_W'(count_q);
    assign issue_end = EXT_W'(cur_addr_q) + (EXT_W'(issue_len) << AXSIZE);
    assign done_end  = EXT_W'(awaddr_q) + (EXT_W'(len_q) << AXSIZE);

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) state_q <= S_IDLE;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (start) state_d = S_ADDR;
            S_ADDR:  if (m_axi_awready) state_d = S_DATA;
            S_DATA:  if (m_axi_wready && m_axi_wlast) state_d = S_RESP;
            S_RESP:  if (m_axi_bvalid) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Next values of the registered AXI outputs and burst bookkeeping.
    always_comb begin
        awaddr_d   = awaddr_q;
        len_d      = len_q;
        beat_d     = beat_q;
        cur_addr_d = cur_addr_q;
        bursts_d   = bursts_q;
        resp_err_d = resp_err_q;
        if ((state_q == S_IDLE) && start) begin
            len_d    = issue_len;
            awaddr_d = (issue_end > WIN_END) ? BASE_ADDR : cur_addr_q;
        end
        if (state_q == S_ADDR) beat_d = '0;
        else if (pop)          beat_d = beat_q + LEN_W'(1);
        if ((state_q == S_RESP) && m_axi_bvalid) begin
            bursts_d   = bursts_q + 16'd1;
            resp_err_d = resp_err_q || (m_axi_bresp != 2'b00);
            cur_addr_d = (done_end >= WIN_END) ? BASE_ADDR : ADDR_WIDTH'(done_end);
        end
        awvalid_d = (state_d == S_ADDR);
        wvalid_d  = (state_d == S_DATA);
        wlast_d   = (state_d == S_DATA) && (beat_d == len_d - LEN_W'(1));
        bready_d  = (state_d == S_RESP);
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            awaddr_q   <= BASE_ADDR;
            cur_addr_q <= BASE_ADDR;
            len_q      <= LEN_W'(BURST_LEN);
            beat_q     <= '0;
            awvalid_q  <= 1'b0;
            wvalid_q   <= 1'b0;
            wlast_q    <= 1'b0;
            bready_q   <= 1'b0;
            bursts_q   <= '0;
            resp_err_q <= 1'b0;
        end else begin
            awaddr_q   <= awaddr_d;
            cur_addr_q <= cur_addr_d;
            len_q      <= len_d;
            beat_q     <= beat_d;
            awvalid_q  <= awvalid_d;
            wvalid_q   <= wvalid_d;
            wlast_q    <= wlast_d;
            bready_q   <= bready_d;
            bursts_q   <= bursts_d;
            resp_err_q <= resp_err_d;
        end
    end

    assign s_axis_tready = tready_q;
    assign m_axi_awaddr  = awaddr_q;
    assign m_axi_awlen   = 8'(len_q - LEN_W'(1));
    assign m_axi_awsize  = 3'(AXSIZE);
    assign m_axi_awburst = 2'b01;
    assign m_axi_awvalid = awvalid_q;
    assign m_axi_wdata   = mem_q[rd_ptr_q];
    assign m_axi_wstrb   = '1;
    assign m_axi_wlast   = wlast_q;
    assign m_axi_wvalid  = wvalid_q;
    assign m_axi_bready  = bready_q;
    assign bursts_done   = bursts_q;
    assign resp_err      = resp_err_q;

endmodule

// File: tb/tb_axis_burst_writer.sv
// Directed bench for axis_burst_writer with default parameters; exercises the flush port
// when BURST_WRITER_FLUSH_EN is defined.
module tb_axis_burst_writer;

    logic        clk = 1'b0;
    logic        rstn;
    logic        s_axis_tvalid, s_axis_tready;
    logic [15:0] s_axis_tdata;
    logic [31:0] m_axi_awaddr;
    logic [7:0]  m_axi_awlen;
    logic [2:0]  m_axi_awsize;
    logic [1:0]  m_axi_awburst;
    logic        m_axi_awvalid, m_axi_awready;
    logic [15:0] m_axi_wdata;
    logic [1:0]  m_axi_wstrb;
    logic        m_axi_wlast, m_axi_wvalid, m_axi_wready;
    logic [1:0]  m_axi_bresp;
    logic        m_axi_bvalid, m_axi_bready;
    logic [15:0] bursts_done;
    logic        resp_err;
`ifdef BURST_WRITER_FLUSH_EN
    logic        flush;
`endif

    axis_burst_writer dut (
        .clk(clk), .rstn(rstn),
`ifdef BURST_WRITER_FLUSH_EN
        .flush(flush),
`endif
        .s_axis_tvalid(s_axis_tvalid), .s_axis_tready(s_axis_tready), .s_axis_tdata(s_axis_tdata),
        .m_axi_awaddr(m_axi_awaddr), .m_axi_awlen(m_axi_awlen), .m_axi_awsize(m_axi_awsize),
        .m_axi_awburst(m_axi_awburst), .m_axi_awvalid(m_axi_awvalid), .m_axi_awready(m_axi_awready),
        .m_axi_wdata(m_axi_wdata), .m_axi_wstrb(m_axi_wstrb), .m_axi_wlast(m_axi_wlast),
        .m_axi_wvalid(m_axi_wvalid), .m_axi_wready(m_axi_wready),
        .m_axi_bresp(m_axi_bresp), .m_axi_bvalid(m_axi_bvalid), .m_axi_bready(m_axi_bready),
        .bursts_done(bursts_done), .resp_err(resp_err)
    );

    always #5 clk = ~clk;

    int unsigned cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Slave-side records of every AW and W handshake, appended only here.
    logic [31:0] aw_addr_q[$];
    logic [7:0]  aw_len_q[$];
    int unsigned aw_cyc_q[$];
    logic [15:0] w_data_q[$];
    logic        w_last_q[$];
    int unsigned w_cyc_q[$];
    always @(negedge clk) begin
        if (rstn && m_axi_awvalid && m_axi_awready) begin
            aw_addr_q.push_back(m_axi_awaddr);
            aw_len_q.push_back(m_axi_awlen);
            aw_cyc_q.push_back(cyc);
        end
        if (rstn && m_axi_wvalid && m_axi_wready) begin
            w_data_q.push_back(m_axi_wdata);
            w_last_q.push_back(m_axi_wlast);
            w_cyc_q.push_back(cyc);
        end
    end

    // Error response injected on the B handshake whose running index equals err_idx.
    int unsigned b_cnt = 0;
    int unsigned err_idx;
    always @(posedge clk) if (rstn && m_axi_bvalid && m_axi_bready) b_cnt <= b_cnt + 1;
    assign m_axi_bresp = (b_cnt == err_idx) ? 2'b10 : 2'b00;

    int unsigned vectors = 0;
    int unsigned miscompares = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] aw_addr_at(input int unsigned i);
        if (i < aw_addr_q.size()) return aw_addr_q[i];
        return 32'hDEAD_BEEF;
    endfunction
    function automatic logic [31:0] aw_len_at(input int unsigned i);
        if (i < aw_len_q.size()) return 32'(aw_len_q[i]);
        return 32'hDEAD_BEEF;
    endfunction
    function automatic logic [31:0] aw_cyc_at(input int unsigned i);
        if (i < aw_cyc_q.size()) return aw_cyc_q[i];
        return 32'hDEAD_BEEF;
    endfunction
    function automatic logic [31:0] w_cyc_at(input int unsigned i);
        if (i < w_cyc_q.size()) return w_cyc_q[i];
        return 32'hDEAD_BEEF;
    endfunction

    // Count recorded W beats from base that differ from first+i, or whose wlast is wrong.
    function automatic int unsigned beat_errs(input int unsigned base, input int unsigned n,
                                              input logic [15:0] first, input int unsigned blen);
        int unsigned e = 0;
        for (int i = 0; i < int'(n); i++) begin
            if (base + i >= w_data_q.size()) e++;
            else if (w_data_q[base+i] !== first + 16'(i) ||
                     w_last_q[base+i] !== ((i % blen) == blen - 1)) e++;
        end
        return e;
    endfunction

    task automatic push_word(input logic [15:0] v);
        int k = 0;
        s_axis_tvalid = 1'b1;
        s_axis_tdata  = v;
        @(negedge clk);
        while (!s_axis_tready && k < 200) begin @(negedge clk); k++; end
        if (!s_axis_tready) chk("push_tready_timeout", 32'(s_axis_tready), 32'd1);
        @(posedge clk); #1;
        s_axis_tvalid = 1'b0;
    endtask

    task automatic wait_wvalid();
        int k = 0;
        @(negedge clk);
        while (!m_axi_wvalid && k < 100) begin @(negedge clk); k++; end
        if (!m_axi_wvalid) chk("wvalid_timeout", 32'(m_axi_wvalid), 32'd1);
    endtask

    task automatic wait_bursts(input string tag, input int unsigned n);
        int k = 0;
        while (bursts_done != 16'(n) && k < 3000) begin @(posedge clk); #1; k++; end
        chk(tag, 32'(bursts_done), n);
    endtask

    task automatic apply_reset();
        @(posedge clk); #1; rstn = 1'b0;
        @(posedge clk); #1; rstn = 1'b1;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: observed no finish expected finish before time limit");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int unsigned base_aw, base_w, t_push, nxt;
        logic        tr_hist[20];
        rstn = 1'b0; s_axis_tvalid = 1'b0; s_axis_tdata = '0;
        m_axi_awready = 1'b1; m_axi_wready = 1'b1; m_axi_bvalid = 1'b1;
        err_idx = 32'hFFFF_FFFF;
`ifdef BURST_WRITER_FLUSH_EN
        flush = 1'b0;
`endif
        repeat (3) @(posedge clk);
        #1; rstn = 1'b1;

        chk("rst_awvalid", 32'(m_axi_awvalid), 32'd0);
        chk("rst_wvalid", 32'(m_axi_wvalid), 32'd0);
        chk("rst_wlast", 32'(m_axi_wlast), 32'd0);
        chk("rst_bready", 32'(m_axi_bready), 32'd0);
        chk("rst_bursts_done", 32'(bursts_done), 32'd0);
        chk("rst_resp_err", 32'(resp_err), 32'd0);
        chk("rst_tready", 32'(s_axis_tready), 32'd1);
        chk("awsize", 32'(m_axi_awsize), 32'd1);
        chk("awburst", 32'(m_axi_awburst), 32'd1);
        chk("wstrb", 32'(m_axi_wstrb), 32'h3);

        // T2: one full burst with all slave handshakes ready
        base_aw = aw_addr_q.size(); base_w = w_data_q.size();
        for (int i = 1; i <= 8; i++) push_word(16'(i));
        t_push = cyc;
        wait_bursts("t2_bursts_done", 1);
        chk("t2_aw_count", aw_addr_q.size() - base_aw, 32'd1);
        chk("t2_awaddr", aw_addr_at(base_aw), 32'd0);
        chk("t2_awlen", aw_len_at(base_aw), 32'd7);
        chk("t2_aw_latency", aw_cyc_at(base_aw), t_push + 1);
        chk("t2_w_count", w_data_q.size() - base_w, 32'd8);
        chk("t2_w_beats", beat_errs(base_w, 8, 16'd1, 8), 32'd0);
        chk("t2_w_first_cycle", w_cyc_at(base_w), aw_cyc_at(base_aw) + 1);
        chk("t2_w_back_to_back", w_cyc_at(base_w + 7), w_cyc_at(base_w) + 7);

        // T3: wready stalls mid-burst
        base_aw = aw_addr_q.size(); base_w = w_data_q.size();
        m_axi_wready = 1'b0;
        for (int i = 0; i < 8; i++) push_word(16'h11 + 16'(i));
        wait_wvalid();
        chk("t3_stall_wdata_a", 32'(m_axi_wdata), 32'h11);
        repeat (2) @(negedge clk);
        chk("t3_stall_wdata_b", 32'(m_axi_wdata), 32'h11);
        @(posedge clk); #1; m_axi_wready = 1'b1;
        repeat (2) @(posedge clk);
        #1; m_axi_wready = 1'b0;
        @(negedge clk);
        chk("t3_stall_wdata_c", 32'(m_axi_wdata), 32'h13);
        repeat (2) @(negedge clk);
        chk("t3_stall_wdata_d", 32'(m_axi_wdata), 32'h13);
        chk("t3_stall_wvalid", 32'(m_axi_wvalid), 32'd1);
        @(posedge clk); #1; m_axi_wready = 1'b1;
        wait_bursts("t3_bursts_done", 2);
        chk("t3_awaddr", aw_addr_at(base_aw), 32'd16);
        chk("t3_w_count", w_data_q.size() - base_w, 32'd8);
        chk("t3_w_beats", beat_errs(base_w, 8, 16'h11, 8), 32'd0);

        // T1: reset while a burst is stuck in its data phase
        m_axi_wready = 1'b0;
        for (int i = 0; i < 8; i++) push_word(16'h31 + 16'(i));
        wait_wvalid();
        @(posedge clk); #1; rstn = 1'b0;
        #1;
        chk("t1_awvalid", 32'(m_axi_awvalid), 32'd0);
        chk("t1_wvalid", 32'(m_axi_wvalid), 32'd0);
        chk("t1_bready", 32'(m_axi_bready), 32'd0);
        chk("t1_bursts_done", 32'(bursts_done), 32'd0);
        chk("t1_tready", 32'(s_axis_tready), 32'd1);
        @(posedge clk); #1; rstn = 1'b1; m_axi_wready = 1'b1;
        base_aw = aw_addr_q.size(); base_w = w_data_q.size();
        for (int i = 0; i < 8; i++) push_word(16'h41 + 16'(i));
        wait_bursts("t1_bursts_after", 1);
        chk("t1_awaddr_base", aw_addr_at(base_aw), 32'd0);
        chk("t1_w_beats", beat_errs(base_w, 8, 16'h41, 8), 32'd0);

        // T4: stream enough bursts to walk the whole window and wrap
        apply_reset();
        base_aw = aw_addr_q.size(); base_w = w_data_q.size();
        for (int i = 0; i < 528; i++) push_word(16'(i));
        wait_bursts("t4_bursts_done", 66);
        chk("t4_aw_count", aw_addr_q.size() - base_aw, 32'd66);
        chk("t4_awaddr_first", aw_addr_at(base_aw), 32'd0);
        chk("t4_awaddr_last_in_window", aw_addr_at(base_aw + 63), 32'd1008);
        chk("t4_awaddr_wrap", aw_addr_at(base_aw + 64), 32'd0);
        chk("t4_awaddr_after_wrap", aw_addr_at(base_aw + 65), 32'd16);
        begin
            int unsigned e = 0;
            for (int i = 0; i < 66; i++)
                if (aw_addr_at(base_aw + i) !== 32'((i * 16) % 1024)) e++;
            chk("t4_awaddr_sequence", e, 32'd0);
        end
        chk("t4_w_beats", beat_errs(base_w, 528, 16'd0, 8), 32'd0);

        // T5: AW stalled while the producer keeps streaming
        apply_reset();
        base_aw = aw_addr_q.size(); base_w = w_data_q.size();
        m_axi_awready = 1'b0;
        nxt = 0;
        s_axis_tvalid = 1'b1; s_axis_tdata = 16'h100;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            tr_hist[c] = s_axis_tready;
            @(posedge clk); #1;
            if (tr_hist[c]) begin nxt++; s_axis_tdata = 16'h100 + 16'(nxt); end
        end
        chk("t5_tready_at_15", 32'(tr_hist[15]), 32'd1);
        chk("t5_tready_at_16", 32'(tr_hist[16]), 32'd0);
        chk("t5_tready_at_19", 32'(tr_hist[19]), 32'd0);
        chk("t5_accepted", nxt, 32'd16);
        chk("t5_no_aw_handshake", aw_addr_q.size() - base_aw, 32'd0);
        m_axi_awready = 1'b1;
        for (int i = 16; i < 32; i++) push_word(16'h100 + 16'(i));
        wait_bursts("t5_bursts_done", 4);
        chk("t5_w_count", w_data_q.size() - base_w, 32'd32);
        chk("t5_w_beats", beat_errs(base_w, 32, 16'h100, 8), 32'd0);

        // T6: error response on the second burst
        apply_reset();
        base_aw = aw_addr_q.size();
        err_idx = b_cnt + 1;
        for (int i = 0; i < 8; i++) push_word(16'h200 + 16'(i));
        wait_bursts("t6_bursts_1", 1);
        chk("t6_resp_err_after_1", 32'(resp_err), 32'd0);
        for (int i = 8; i < 16; i++) push_word(16'h200 + 16'(i));
        wait_bursts("t6_bursts_2", 2);
        chk("t6_resp_err_after_2", 32'(resp_err), 32'd1);
        for (int i = 16; i < 24; i++) push_word(16'h200 + 16'(i));
        wait_bursts("t6_bursts_3", 3);
        chk("t6_resp_err_sticky", 32'(resp_err), 32'd1);
        chk("t6_awaddr_burst3", aw_addr_at(base_aw + 2), 32'd32);
        err_idx = 32'hFFFF_FFFF;

`ifdef BURST_WRITER_FLUSH_EN
        // Short burst of three words released by flush
        base_aw = aw_addr_q.size(); base_w = w_data_q.size();
        for (int i = 0; i < 3; i++) push_word(16'h61 + 16'(i));
        repeat (10) @(posedge clk);
        #1;
        chk("fl_no_aw_without_flush", aw_addr_q.size() - base_aw, 32'd0);
        flush = 1'b1;
        wait_bursts("fl_bursts_done", 4);
        flush = 1'b0;
        chk("fl_awaddr", aw_addr_at(base_aw), 32'd48);
        chk("fl_awlen", aw_len_at(base_aw), 32'd2);
        chk("fl_w_count", w_data_q.size() - base_w, 32'd3);
        chk("fl_w_beats", beat_errs(base_w, 3, 16'h61, 3), 32'd0);
`endif

        repeat (5) @(posedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
